// File: rtl/alu_issue_ctrl.sv
// Round-robin issue controller sharing one integer ALU between requesters.
// Holds operands for ALU_LAT cycles and returns results over valid/ready.
module alu_issue_ctrl #(
  parameter int NUM_REQ = 2,
  parameter int ALU_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [5*NUM_REQ-1:0] req_op,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic [4:0]           alu_control,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  input  logic [31:0]          alu_result,
  input  logic [1:0]           alu_flags,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [1:0]           rsp_id,
  output logic [31:0]          rsp_result,
  output logic [1:0]           rsp_flags,
  output logic                 rsp_err,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [4:0] OP_DIV = 5'b00011;
  localparam logic [4:0] OP_MOD = 5'b00100;
  localparam logic [4:0] OP_CMP = 5'b00101;
  localparam logic [4:0] OP_MAX = 5'b01100;

  state_t      state_q;
  logic [1:0]  last_q;
  logic [3:0]  cnt_q;
  logic [4:0]  ctl_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [1:0]  id_q;
  logic [31:0] res_q;
  logic [1:0]  flg_q;
  logic        err_q;

  // Requester lanes padded to four so every index is exactly 2 bits wide.
  logic [4:0]  ops [4];
  logic [31:0] as  [4];
  logic [31:0] bs  [4];
  logic [3:0]  vld4;
  logic [3:0]  rdy4;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    if (i < NUM_REQ) begin : g_on
      assign ops[i] = req_op[5*i +: 5];
      assign as[i]  = req_a[32*i +: 32];
      assign bs[i]  = req_b[32*i +: 32];
    end else begin : g_off
      assign ops[i] = '0;
      assign as[i]  = '0;
      assign bs[i]  = '0;
    end
  end

  assign vld4 = 4'(req_valid);

  logic [1:0]  gnt;
  logic        gnt_vld;
  logic [2:0]  sum;

  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    sum     = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      sum = {1'b0, last_q} + 3'(k);
      if (sum >= 3'(NUM_REQ)) sum = sum - 3'(NUM_REQ);
      if (vld4[sum[1:0]]) begin
        gnt     = sum[1:0];
        gnt_vld = 1'b1;
      end
    end
  end

  logic [4:0]  op_sel;
  logic [31:0] a_sel;
  logic [31:0] b_sel;
  logic        trap;

  assign op_sel = ops[gnt];
  assign a_sel  = as[gnt];
  assign b_sel  = bs[gnt];
  assign trap   = (((op_sel == OP_DIV) || (op_sel == OP_MOD))
                   && (b_sel == 32'd0)) || (op_sel > OP_MAX);

  assign rdy4 = ((state_q == IDLE) && gnt_vld) ? (4'b0001 << gnt) : 4'b0000;
  assign req_ready = rdy4[NUM_REQ-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 2'(NUM_REQ - 1);
      cnt_q   <= '0;
      ctl_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            id_q   <= gnt;
            last_q <= gnt;
            if (trap) begin
              res_q   <= '0;
              flg_q   <= '0;
              err_q   <= 1'b1;
              state_q <= RESP;
            end else begin
              ctl_q   <= op_sel;
              a_q     <= a_sel;
              b_q     <= b_sel;
              cnt_q   <= 4'(ALU_LAT);
              state_q <= EXEC;
            end
          end
        end
        EXEC: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            res_q   <= alu_result;
            flg_q   <= (ctl_q == OP_CMP) ? alu_flags : 2'b00;
            err_q   <= 1'b0;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_control = ctl_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign rsp_valid   = (state_q == RESP);
  assign rsp_id      = id_q;
  assign rsp_result  = res_q;
  assign rsp_flags   = flg_q;
  assign rsp_err     = err_q;
  assign busy        = (state_q != IDLE);

endmodule
